fifo_rd_chk: RTL and testbench
==============================

Name: fifo_rd_chk

Overview:
- Consumer stage directly downstream of the byte FIFO fed by the LFSR generator (`gen`).
- Pops bytes from the FIFO read port in frames of FRAME_LEN bytes.
- Accumulates a 16-bit checksum and byte count, and flags stream errors: MSB set, or a repeated consecutive value.
- Gated by the same global ENwrk enable as the generator; reports frame completion to the top-level controller.

Parameters:
- FRAME_LEN, 16: bytes read per frame; legal range 1..65535.
- RD_LAT, 1: FIFO read latency, in clocks from the rdreq-high cycle to the q-valid cycle; legal range 1..4.
- TIMEOUT, 1024: empty-wait limit in cycles; used only when FIFO_RD_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a frame when idle
- ENwrk  in  1  global work enable; 0 pauses new reads
- empty  in  1  FIFO empty flag
- q  in  8  FIFO read data
- rdreq  out  1  FIFO read request, registered
- busy  out  1  high while a frame is in progress
- frame_done  out  1  one-cycle pulse at frame end
- byte_cnt  out  16  bytes captured in the current or last frame
- checksum  out  16  sum of captured bytes mod 2^16
- err_msb  out  1  sticky: a captured byte had q[7]=1
- err_repeat  out  1  sticky: a captured byte equalled the previous one in the same frame
- err_timeout  out  1  sticky timeout flag; tied 0 when the feature is excluded

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0; internal prev-byte and latency counter 0.
- FSM states: IDLE, RUN, WAIT, DONE.
- IDLE:
  - busy=0.
  - start=1 clears byte_cnt, checksum, all err_* flags and the prev-valid flag, then moves to RUN.
- RUN:
  - busy=1.
  - If ENwrk=1 and empty=0 at an edge: rdreq<=1 for exactly one cycle, latency counter<=RD_LAT, go to WAIT.
  - Otherwise stay in RUN with rdreq=0.
- WAIT:
  - rdreq<=0; counter decrements each cycle.
  - Capture edge: if rdreq is high in cycle T, q is sampled at the edge ending cycle T+RD_LAT.
  - On capture:
    - checksum += {8'h00,q}, wrapping mod 2^16.
    - byte_cnt += 1.
    - err_msb |= q[7].
    - err_repeat |= (prev_valid && q==prev); then prev<=q, prev_valid<=1.
  - After capture: if the new byte_cnt equals FRAME_LEN go to DONE, else go to RUN.
- DONE: frame_done=1 for one cycle, busy=0 from the next cycle, go to IDLE.
- byte_cnt, checksum and err_* hold their values until the next accepted start.
- Outstanding reads: at most one. Throughput is one byte per RD_LAT+2 cycles when the FIFO is never empty.
- ENwrk:
  - ENwrk=0 only blocks issuing rdreq.
  - A read already issued (WAIT) still completes and is counted.
- start while busy (RUN, WAIT or DONE) is ignored; start coincident with the DONE cycle is ignored.
- empty is sampled only in RUN. No underflow read is ever issued (this block is the FIFO's sole reader).
- Reset mid-frame aborts immediately: rdreq=0, counters cleared, no frame_done.
- FRAME_LEN=1: a single capture goes straight to DONE.

Optional Feature:
- Macro: FIFO_RD_TIMEOUT_EN.
- Defined:
  - A wait counter counts consecutive RUN cycles with empty=1 or ENwrk=0; it clears on leaving RUN.
  - When it reaches TIMEOUT: err_timeout<=1, go to DONE, frame_done pulses, byte_cnt holds the partial count.
- Not defined: no wait counter; err_timeout is constant 0; RUN waits indefinitely.

Test Plan:
- Reset: hold rst_n=0 with start=1, ENwrk=1, empty=0. Required: rdreq, busy, frame_done, byte_cnt, checksum and all err_* = 0.
- Nominal, FRAME_LEN=4, RD_LAT=1, FIFO preloaded 8'h01,8'h02,8'h03,8'h04, start pulse:
  - 4 rdreq pulses spaced 3 cycles apart.
  - frame_done once; byte_cnt=4; checksum=16'h000A; err_*=0.
- Errors: bytes 8'h85,8'h10,8'h10,8'h20. Required: err_msb=1, err_repeat=1, checksum=16'h00C5.
- Checksum wrap: FRAME_LEN=258, every byte 8'hFF with alternating 8'hFE, repeats avoided. Required: checksum equals the golden sum mod 2^16, byte_cnt=258.
- Pause and reset:
  - Drop ENwrk on the rdreq cycle: the outstanding byte is still captured and no further rdreq is issued until ENwrk=1.
  - Assert rst_n=0 in WAIT: all outputs return to 0 and no frame_done.
- Timeout (FIFO_RD_TIMEOUT_EN, TIMEOUT=8): 2 bytes available, then empty held. Required: err_timeout=1, frame_done pulse, byte_cnt=2.

Source files
------------

// File: rtl/fifo_rd_chk_if.sv
// FIFO read port as seen by the frame reader.
// master: the reader (drives rdreq); slave: the FIFO (drives empty and q).
interface fifo_rd_chk_if;
  logic       rdreq;
  logic       empty;
  logic [7:0] q;

  modport master (output rdreq, input empty, input q);
  modport slave  (input rdreq, output empty, output q);
endinterface

// File: rtl/fifo_rd_chk.sv
// fifo_rd_chk: pops FRAME_LEN bytes per frame from the FIFO read port,
// accumulating a 16-bit checksum and byte count and flagging bytes with the
// MSB set or repeating the previous byte of the frame.
// Optional macro FIFO_RD_TIMEOUT_EN: abort a frame after TIMEOUT consecutive
// RUN cycles without being able to issue a read, raising err_timeout.
module fifo_rd_chk #(
  parameter int FRAME_LEN = 16,
  parameter int RD_LAT    = 1,
  parameter int TIMEOUT   = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          ENwrk,
  fifo_rd_chk_if.master fifo,
  output logic          busy,
  output logic          frame_done,
  output logic [15:0]   byte_cnt,
  output logic [15:0]   checksum,
  output logic          err_msb,
  output logic          err_repeat,
  output logic          err_timeout
);

  // Reject parameter values the datapath widths cannot represent.
  if (FRAME_LEN < 1 || FRAME_LEN > 65535 || RD_LAT < 1 || RD_LAT > 4 || TIMEOUT < 1) begin : g_bad_params
    $error("fifo_rd_chk: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, RUN, WAIT, DONE} state_t;

  // byte_cnt value just before the final capture of a frame
  localparam logic [15:0] FRAME_LAST = 16'(FRAME_LEN - 1);
  localparam logic [2:0]  LAT_INIT   = 3'(RD_LAT);

  state_t     state;
  logic       rdreq;
  logic [2:0] lat_cnt;
  logic [7:0] prev;
  logic       prev_valid;
  logic       read_ok;

`ifdef FIFO_RD_TIMEOUT_EN
  localparam int             WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  logic [WAIT_W-1:0] wait_cnt;
`else
  assign err_timeout = 1'b0;
`endif

  // A read may only be issued while enabled and the FIFO holds data; with a
  // single reader this alone guarantees no underflow.
  assign read_ok    = ENwrk && !fifo.empty;
  assign fifo.rdreq = rdreq;

  // Frame FSM: issues one read at a time, waits RD_LAT cycles, captures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rdreq       <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      byte_cnt    <= '0;
      checksum    <= '0;
      err_msb     <= 1'b0;
      err_repeat  <= 1'b0;
      lat_cnt     <= '0;
      prev        <= '0;
      prev_valid  <= 1'b0;
`ifdef FIFO_RD_TIMEOUT_EN
      err_timeout <= 1'b0;
      wait_cnt    <= '0;
`endif
    end else begin
      // rdreq and frame_done are single-cycle pulses unless re-asserted below
      rdreq      <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            byte_cnt    <= '0;
            checksum    <= '0;
            err_msb     <= 1'b0;
            err_repeat  <= 1'b0;
            prev_valid  <= 1'b0;
            busy        <= 1'b1;
            state       <= RUN;
`ifdef FIFO_RD_TIMEOUT_EN
            err_timeout <= 1'b0;
            wait_cnt    <= '0;
`endif
          end
        end
        RUN: begin
          if (read_ok) begin
            rdreq   <= 1'b1;
            lat_cnt <= LAT_INIT;
            state   <= WAIT;
`ifdef FIFO_RD_TIMEOUT_EN
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            // Starved for TIMEOUT cycles: close the frame with a partial count.
            wait_cnt    <= '0;
            err_timeout <= 1'b1;
            frame_done  <= 1'b1;
            state       <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
`endif
          end
        end
        WAIT: begin
          // lat_cnt reaches 0 on the edge that ends the q-valid cycle
          if (lat_cnt == 3'd0) begin
            checksum   <= checksum + {8'h00, fifo.q};
            byte_cnt   <= byte_cnt + 16'd1;
            err_msb    <= err_msb | fifo.q[7];
            err_repeat <= err_repeat | (prev_valid && (fifo.q == prev));
            prev       <= fifo.q;
            prev_valid <= 1'b1;
            if (byte_cnt == FRAME_LAST) begin
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              state <= RUN;
            end
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        DONE: begin
          // start here is deliberately ignored; busy drops as IDLE begins
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_chk.sv
// Testbench for fifo_rd_chk: two instances (4-byte frames with RD_LAT=1 and
// 258-byte frames with RD_LAT=2), each fed by a queue-based FIFO model.
// Expected frame results come from plain arithmetic over the bytes pushed.
`timescale 1ns/1ps
module tb_fifo_rd_chk;
  localparam int N_CH = 2;
  localparam int FL0  = 4;
  localparam int LAT0 = 1;
  localparam int FL1  = 258;
  localparam int LAT1 = 2;
  localparam int TO   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N_CH-1:0] start = '0;
  logic [N_CH-1:0] en = '0;

  logic        rdreq_mon   [N_CH];
  logic        busy        [N_CH];
  logic        frame_done  [N_CH];
  logic [15:0] byte_cnt    [N_CH];
  logic [15:0] checksum    [N_CH];
  logic        err_msb     [N_CH];
  logic        err_repeat  [N_CH];
  logic        err_timeout [N_CH];

  logic [7:0] fifo_q [N_CH][$];
  int under_cnt [N_CH] = '{0, 0};
  int rd_cnt [N_CH];
  int done_cnt [N_CH];
  int last_rd [N_CH];
  int min_gap [N_CH];
  int max_gap [N_CH];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    localparam int FL  = (gi == 0) ? FL0 : FL1;
    localparam int LAT = (gi == 0) ? LAT0 : LAT1;

    fifo_rd_chk_if fif ();
    logic [7:0] pipe [LAT];

    assign fif.q = pipe[LAT-1];
    assign rdreq_mon[gi] = fif.rdreq;

    fifo_rd_chk #(.FRAME_LEN(FL), .RD_LAT(LAT), .TIMEOUT(TO)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start[gi]), .ENwrk(en[gi]), .fifo(fif),
      .busy(busy[gi]), .frame_done(frame_done[gi]), .byte_cnt(byte_cnt[gi]),
      .checksum(checksum[gi]), .err_msb(err_msb[gi]), .err_repeat(err_repeat[gi]),
      .err_timeout(err_timeout[gi])
    );

    // FIFO model: a read sampled high pops the front; data appears LAT cycles on.
    always @(posedge clk) begin
      logic [7:0] v;
      v = 8'($urandom);
      if (fif.rdreq) begin
        if (fifo_q[gi].size() == 0) under_cnt[gi]++;
        else v = fifo_q[gi].pop_front();
      end
      pipe[0] <= v;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
      fif.empty <= (fifo_q[gi].size() == 0);
    end

    // Monitor: rdreq pulses, their spacing, and frame_done pulses.
    always @(posedge clk) begin
      #1;
      if (fif.rdreq) begin
        if (last_rd[gi] >= 0) begin
          if (cyc - last_rd[gi] < min_gap[gi]) min_gap[gi] = cyc - last_rd[gi];
          if (cyc - last_rd[gi] > max_gap[gi]) max_gap[gi] = cyc - last_rd[gi];
        end
        last_rd[gi] = cyc;
        rd_cnt[gi]++;
      end
      if (frame_done[gi]) done_cnt[gi]++;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] m_sum(input logic [7:0] b[$]);
    int s = 0;
    foreach (b[i]) s += int'(b[i]);
    return 16'(s);
  endfunction

  function automatic logic m_msb(input logic [7:0] b[$]);
    foreach (b[i]) if (b[i] >= 8'h80) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_rep(input logic [7:0] b[$]);
    for (int i = 1; i < b.size(); i++) if (b[i] == b[i-1]) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic clear_mon(input int c);
    rd_cnt[c] = 0;
    done_cnt[c] = 0;
    last_rd[c] = -1;
    min_gap[c] = 1 << 30;
    max_gap[c] = 0;
  endtask

  task automatic push_all(input int c, input logic [7:0] b[$]);
    foreach (b[i]) fifo_q[c].push_back(b[i]);
  endtask

  task automatic pulse_start(input int c);
    @(negedge clk);
    start[c] = 1'b1;
    @(negedge clk);
    start[c] = 1'b0;
  endtask

  task automatic wait_done(input int c, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt[c] > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rdreq(input int c, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rdreq_mon[c]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    logic [37:0] obs;
    rst_n = 1'b0;
    start = '1;
    en = '1;
    fifo_q[0].push_back(8'h11);
    fifo_q[1].push_back(8'h22);
    repeat (4) @(negedge clk);
    for (int c = 0; c < N_CH; c++) begin
      obs = {rdreq_mon[c], busy[c], frame_done[c], err_msb[c], err_repeat[c], err_timeout[c],
             byte_cnt[c], checksum[c]};
      checks++;
      if (obs !== 38'd0) begin
        errors++;
        $display("FAIL reset_outputs ch%0d: got %h want 0", c, obs);
      end
    end
    start = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < N_CH; c++) fifo_q[c].delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_nominal;
    logic [7:0] b[$] = '{8'h01, 8'h02, 8'h03, 8'h04};
    bit ok;
    clear_mon(0);
    push_all(0, b);
    pulse_start(0);
    wait_done(0, 100, ok);
    $display("nominal ch0: bytes=%0d checksum=%h", byte_cnt[0], checksum[0]);
    checks++; if (!ok) begin errors++; $display("FAIL nominal_done: no frame_done within 100 cycles"); end
    checks++; if (rd_cnt[0] !== 4) begin errors++; $display("FAIL nominal_rdreq_count: got %0d want 4", rd_cnt[0]); end
    checks++; if (min_gap[0] !== 3 || max_gap[0] !== 3) begin
      errors++; $display("FAIL nominal_rdreq_spacing: got %0d..%0d want 3", min_gap[0], max_gap[0]);
    end
    checks++; if (byte_cnt[0] !== 16'd4) begin errors++; $display("FAIL nominal_byte_cnt: got %0d want 4", byte_cnt[0]); end
    checks++; if (checksum[0] !== 16'h000A) begin errors++; $display("FAIL nominal_checksum: got %h want 000a", checksum[0]); end
    checks++; if ({err_msb[0], err_repeat[0], err_timeout[0]} !== 3'b000) begin
      errors++; $display("FAIL nominal_errs: got %b%b%b want 000", err_msb[0], err_repeat[0], err_timeout[0]);
    end
    repeat (3) @(negedge clk);
    checks++; if (done_cnt[0] !== 1 || busy[0] !== 1'b0) begin
      errors++; $display("FAIL nominal_end: got done=%0d busy=%b want 1,0", done_cnt[0], busy[0]);
    end
  endtask

  task automatic test_errors;
    logic [7:0] b[$] = '{8'h85, 8'h10, 8'h10, 8'h20};
    bit ok;
    clear_mon(0);
    push_all(0, b);
    pulse_start(0);
    wait_done(0, 100, ok);
    $display("errors ch0: bytes=%0d checksum=%h msb=%b rep=%b", byte_cnt[0], checksum[0], err_msb[0], err_repeat[0]);
    checks++; if (!ok) begin errors++; $display("FAIL errors_done: no frame_done within 100 cycles"); end
    checks++; if (err_msb[0] !== 1'b1) begin errors++; $display("FAIL errors_msb: got %b want 1", err_msb[0]); end
    checks++; if (err_repeat[0] !== 1'b1) begin errors++; $display("FAIL errors_repeat: got %b want 1", err_repeat[0]); end
    checks++; if (checksum[0] !== 16'h00C5) begin errors++; $display("FAIL errors_checksum: got %h want 00c5", checksum[0]); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_start_busy;
    logic [7:0] b[$] = '{8'h21, 8'h43, 8'h65, 8'h07};
    bit ok;
    clear_mon(0);
    push_all(0, b);
    pulse_start(0);
    repeat (4) @(negedge clk);
    pulse_start(0);
    wait_done(0, 100, ok);
    // start coincident with the DONE cycle must not open a new frame
    start[0] = 1'b1;
    fifo_q[0].push_back(8'h55);
    @(negedge clk);
    start[0] = 1'b0;
    repeat (6) @(negedge clk);
    $display("start_busy ch0: bytes=%0d checksum=%h", byte_cnt[0], checksum[0]);
    checks++; if (!ok) begin errors++; $display("FAIL start_busy_done: no frame_done within 100 cycles"); end
    checks++; if (byte_cnt[0] !== 16'd4 || checksum[0] !== m_sum(b)) begin
      errors++; $display("FAIL start_busy_result: got cnt=%0d sum=%h want 4,%h", byte_cnt[0], checksum[0], m_sum(b));
    end
    checks++; if (rd_cnt[0] !== 4 || done_cnt[0] !== 1 || busy[0] !== 1'b0) begin
      errors++; $display("FAIL start_busy_ignored: got rd=%0d done=%0d busy=%b want 4,1,0", rd_cnt[0], done_cnt[0], busy[0]);
    end
    fifo_q[0].delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_pause;
    logic [7:0] b[$] = '{8'h0C, 8'h1D, 8'h2E, 8'h3F};
    bit ok;
    clear_mon(0);
    push_all(0, b);
    pulse_start(0);
    wait_rdreq(0, 20, ok);
    en[0] = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL pause_first_rdreq: no rdreq within 20 cycles"); end
    repeat (6) @(negedge clk);
    checks++; if (byte_cnt[0] !== 16'd1 || rd_cnt[0] !== 1) begin
      errors++; $display("FAIL pause_hold: got cnt=%0d rd=%0d want 1,1", byte_cnt[0], rd_cnt[0]);
    end
    en[0] = 1'b1;
    wait_done(0, 100, ok);
    $display("pause ch0: bytes=%0d checksum=%h", byte_cnt[0], checksum[0]);
    checks++; if (!ok || byte_cnt[0] !== 16'd4 || checksum[0] !== m_sum(b)) begin
      errors++; $display("FAIL pause_resume: got ok=%b cnt=%0d sum=%h want 1,4,%h", ok, byte_cnt[0], checksum[0], m_sum(b));
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random;
    for (int f = 0; f < 6; f++) begin
      logic [7:0] b[$];
      bit ok = 1'b0;
      int idx = 0;
      int stall = 0;
      for (int i = 0; i < FL0; i++) begin
        if (i > 0 && $urandom_range(0, 3) == 0) b.push_back(b[i-1]);
        else b.push_back(8'($urandom_range(0, 255)));
      end
      clear_mon(0);
      pulse_start(0);
      for (int t = 0; t < 300 && !ok; t++) begin
        @(negedge clk);
        if (done_cnt[0] > 0) ok = 1'b1;
        if (idx < FL0 && ($urandom_range(0, 2) != 0 || stall >= 4)) begin
          fifo_q[0].push_back(b[idx]);
          idx++;
        end
        en[0] = ($urandom_range(0, 3) != 0) || (stall >= 4);
        if (!en[0] || fifo_q[0].size() == 0) stall++;
        else stall = 0;
      end
      en[0] = 1'b1;
      $display("random ch0 frame %0d: bytes=%0d checksum=%h msb=%b rep=%b", f, byte_cnt[0], checksum[0],
               err_msb[0], err_repeat[0]);
      checks++; if (!ok) begin errors++; $display("FAIL random_done f%0d: no frame_done within 300 cycles", f); end
      checks++; if (byte_cnt[0] !== 16'(FL0) || checksum[0] !== m_sum(b)) begin
        errors++; $display("FAIL random_sum f%0d: got cnt=%0d sum=%h want %0d,%h", f, byte_cnt[0], checksum[0], FL0, m_sum(b));
      end
      checks++; if (err_msb[0] !== m_msb(b) || err_repeat[0] !== m_rep(b)) begin
        errors++; $display("FAIL random_flags f%0d: got msb=%b rep=%b want %b,%b", f, err_msb[0], err_repeat[0], m_msb(b), m_rep(b));
      end
      checks++; if (rd_cnt[0] !== FL0 || min_gap[0] < LAT0 + 2) begin
        errors++; $display("FAIL random_reads f%0d: got rd=%0d min_gap=%0d want %0d,>=%0d", f, rd_cnt[0], min_gap[0], FL0, LAT0 + 2);
      end
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_wrap;
    logic [7:0] b[$];
    bit ok;
    for (int i = 0; i < FL1; i++) b.push_back((i % 2 == 0) ? 8'hFF : 8'hFE);
    clear_mon(1);
    push_all(1, b);
    pulse_start(1);
    wait_done(1, 2000, ok);
    $display("wrap ch1: bytes=%0d checksum=%h", byte_cnt[1], checksum[1]);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_done: no frame_done within 2000 cycles"); end
    checks++; if (byte_cnt[1] !== 16'(FL1)) begin errors++; $display("FAIL wrap_byte_cnt: got %0d want %0d", byte_cnt[1], FL1); end
    checks++; if (checksum[1] !== m_sum(b) || checksum[1] !== 16'h007D) begin
      errors++; $display("FAIL wrap_checksum: got %h want %h", checksum[1], m_sum(b));
    end
    checks++; if (err_msb[1] !== 1'b1 || err_repeat[1] !== 1'b0) begin
      errors++; $display("FAIL wrap_flags: got msb=%b rep=%b want 1,0", err_msb[1], err_repeat[1]);
    end
    checks++; if (min_gap[1] !== LAT1 + 2 || max_gap[1] !== LAT1 + 2) begin
      errors++; $display("FAIL wrap_throughput: got %0d..%0d want %0d", min_gap[1], max_gap[1], LAT1 + 2);
    end
    repeat (3) @(negedge clk);
  endtask

`ifdef FIFO_RD_TIMEOUT_EN
  task automatic test_timeout;
    logic [7:0] b[$] = '{8'h31, 8'h42};
    bit ok;
    clear_mon(0);
    push_all(0, b);
    pulse_start(0);
    wait_done(0, 100, ok);
    $display("timeout ch0: bytes=%0d checksum=%h to=%b", byte_cnt[0], checksum[0], err_timeout[0]);
    checks++; if (!ok) begin errors++; $display("FAIL timeout_done: no frame_done within 100 cycles"); end
    checks++; if (err_timeout[0] !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b want 1", err_timeout[0]); end
    checks++; if (byte_cnt[0] !== 16'd2 || checksum[0] !== m_sum(b)) begin
      errors++; $display("FAIL timeout_partial: got cnt=%0d sum=%h want 2,%h", byte_cnt[0], checksum[0], m_sum(b));
    end
    repeat (3) @(negedge clk);
    checks++; if (done_cnt[0] !== 1 || busy[0] !== 1'b0) begin
      errors++; $display("FAIL timeout_end: got done=%0d busy=%b want 1,0", done_cnt[0], busy[0]);
    end
  endtask
`else
  task automatic test_timeout;
    logic [7:0] b[$] = '{8'h31, 8'h42};
    logic [7:0] r[$] = '{8'h53, 8'h64};
    bit ok;
    clear_mon(0);
    push_all(0, b);
    pulse_start(0);
    repeat (40) @(negedge clk);
    checks++; if (done_cnt[0] !== 0 || busy[0] !== 1'b1 || byte_cnt[0] !== 16'd2 || err_timeout[0] !== 1'b0) begin
      errors++; $display("FAIL no_timeout_wait: got done=%0d busy=%b cnt=%0d to=%b want 0,1,2,0",
                         done_cnt[0], busy[0], byte_cnt[0], err_timeout[0]);
    end
    push_all(0, r);
    wait_done(0, 100, ok);
    $display("no_timeout ch0: bytes=%0d checksum=%h", byte_cnt[0], checksum[0]);
    checks++; if (!ok || byte_cnt[0] !== 16'd4 || checksum[0] !== m_sum({b, r})) begin
      errors++; $display("FAIL no_timeout_finish: got ok=%b cnt=%0d sum=%h want 1,4,%h", ok, byte_cnt[0], checksum[0], m_sum({b, r}));
    end
    repeat (3) @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid;
    logic [7:0] b[$] = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
    logic [37:0] obs;
    bit ok;
    clear_mon(0);
    push_all(0, b);
    pulse_start(0);
    wait_rdreq(0, 20, ok);
    rst_n = 1'b0;
    #1;
    obs = {rdreq_mon[0], busy[0], frame_done[0], err_msb[0], err_repeat[0], err_timeout[0], byte_cnt[0], checksum[0]};
    checks++; if (!ok || obs !== 38'd0) begin
      errors++; $display("FAIL reset_mid_outputs: got ok=%b outputs=%h want 1,0", ok, obs);
    end
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (done_cnt[0] !== 0 || busy[0] !== 1'b0) begin
      errors++; $display("FAIL reset_mid_no_done: got done=%0d busy=%b want 0,0", done_cnt[0], busy[0]);
    end
    fifo_q[0].delete();
  endtask

  initial begin
    for (int c = 0; c < N_CH; c++) clear_mon(c);
    test_reset();
    test_nominal();
    test_errors();
    test_start_busy();
    test_pause();
    test_random();
    test_wrap();
    test_timeout();
    test_reset_mid();
    for (int c = 0; c < N_CH; c++) begin
      checks++;
      if (under_cnt[c] !== 0) begin
        errors++; $display("FAIL underflow ch%0d: got %0d reads of an empty FIFO want 0", c, under_cnt[c]);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
